// File: rtl/ef_psram_qspi_target_if.sv
// QPI link between a PSRAM controller (master) and the PSRAM device (slave).
interface ef_psram_qspi_target_if;
   logic       sck;
   logic       ce_n;
   logic [3:0] din;
   logic [3:0] dout;
   logic [3:0] douten;

   modport master (
      output sck,
      output ce_n,
      output din,
      input  dout,
      input  douten
   );

   modport slave (
      input  sck,
      input  ce_n,
      input  din,
      output dout,
      output douten
   );
endinterface

// File: rtl/ef_psram_qspi_target.sv
// QPI PSRAM target: oversamples the controller link on clk_i and serves
// quad read (0xEB) / quad write (0x38) from an internal byte array.
module ef_psram_qspi_target #(
   parameter int ADDR_W = 10,
   parameter int DUMMY  = 6
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   ef_psram_qspi_target_if.slave        qspi,
   output logic                         busy_o,
   output logic                         err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_RDATA,
      S_WDATA,
      S_IGNORE
   } state_t;

   state_t            state;
   logic [1:0]        sck_s;
   logic [1:0]        ce_s;
   logic [3:0]        din_s0;
   logic [3:0]        din_s1;
   logic              sck_q;
   logic              ce_q;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        hi;
   logic [3:0]        cnt;
   logic              nib;
   logic              rd;
   logic [7:0]        mem [2**ADDR_W];

   logic              rise;
   logic              fall;
   logic              ce_fall;
   logic              ce_rise;
   logic              we;
   logic [7:0]        cmd_byte;
   logic [7:0]        rd_byte;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sck_s  <= 2'b00;
         ce_s   <= 2'b11;
         din_s0 <= '0;
         din_s1 <= '0;
         sck_q  <= 1'b0;
         ce_q   <= 1'b1;
      end else begin
         sck_s  <= {sck_s[0], qspi.sck};
         ce_s   <= {ce_s[0], qspi.ce_n};
         din_s0 <= qspi.din;
         din_s1 <= din_s0;
         sck_q  <= sck_s[1];
         ce_q   <= ce_s[1];
      end
   end

   always_comb begin
      rise     = sck_s[1] & ~sck_q;
      fall     = ~sck_s[1] & sck_q;
      ce_fall  = ~ce_s[1] & ce_q;
      ce_rise  = ce_s[1] & ~ce_q;
      cmd_byte = {hi, din_s1};
      rd_byte  = mem[addr];
      we       = rst_ni && !ce_rise && (state == S_WDATA)
                 && rise && nib;
   end

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[addr] <= {hi, din_s1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         addr        <= '0;
         hi          <= '0;
         cnt         <= '0;
         nib         <= 1'b0;
         rd          <= 1'b0;
         qspi.dout   <= '0;
         qspi.douten <= '0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         err_o <= 1'b0;
         // ce_n release overrides any sck edge seen in the same cycle
         if (ce_rise) begin
            state       <= S_IDLE;
            qspi.dout   <= '0;
            qspi.douten <= '0;
            busy_o      <= 1'b0;
            cnt         <= '0;
            nib         <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (ce_fall) begin
                     state  <= S_CMD;
                     busy_o <= 1'b1;
                     cnt    <= '0;
                     nib    <= 1'b0;
                  end
               end
               S_CMD: begin
                  if (rise) begin
                     hi  <= din_s1;
                     nib <= ~nib;
                     if (nib) begin
                        cnt <= '0;
                        if (cmd_byte == 8'hEB) begin
                           state <= S_ADDR;
                           rd    <= 1'b1;
                        end else if (cmd_byte == 8'h38) begin
                           state <= S_ADDR;
                           rd    <= 1'b0;
                        end else begin
                           state <= S_IGNORE;
                           err_o <= 1'b1;
                        end
                     end
                  end
               end
               S_ADDR: begin
                  // upper address nibbles shift out past ADDR_W
                  if (rise) begin
                     addr <= {addr[ADDR_W-5:0], din_s1};
                     cnt  <= cnt + 4'd1;
                     if (cnt == 4'd5) begin
                        cnt <= '0;
                        if (!rd) begin
                           state <= S_WDATA;
                        end else if (DUMMY == 0) begin
                           state <= S_RDATA;
                        end else begin
                           state <= S_DUMMY;
                        end
                     end
                  end
               end
               S_DUMMY: begin
                  if (rise) begin
                     cnt <= cnt + 4'd1;
                     if (cnt == 4'(DUMMY - 1)) begin
                        cnt   <= '0;
                        state <= S_RDATA;
                     end
                  end
               end
               S_RDATA: begin
                  if (fall) begin
                     qspi.dout   <= nib ? rd_byte[3:0]
                                        : rd_byte[7:4];
                     qspi.douten <= 4'hF;
                     nib         <= ~nib;
                     if (nib) begin
                        addr <= addr + ADDR_W'(1);
                     end
                  end
               end
               S_WDATA: begin
                  if (rise) begin
                     nib <= ~nib;
                     if (!nib) begin
                        hi <= din_s1;
                     end else begin
                        addr <= addr + ADDR_W'(1);
                     end
                  end
               end
               S_IGNORE: begin
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ef_psram_qspi_target.sv
// Self-checking bench for ef_psram_qspi_target: directed cases plus
// random writes/reads against a byte-array reference model.
module tb_ef_psram_qspi_target;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int DUMMY  = 6;
   localparam int H      = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic err;

   ef_psram_qspi_target_if bus();

   ef_psram_qspi_target #(
      .ADDR_W(ADDR_W),
      .DUMMY (DUMMY)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .qspi  (bus),
      .busy_o(busy),
      .err_o (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int err_cnt = 0;
   int err_exp = 0;
   logic [7:0] ref_mem [DEPTH];
   bit         valid [DEPTH];

   always @(posedge clk) if (rst_n && err) err_cnt++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // one sck period: low phase (sample dout), rise, high phase, fall
   task automatic nib(input logic [3:0] d, output logic [3:0] q,
                      output logic [3:0] oe);
      bus.din = d;
      repeat (H) @(negedge clk);
      q  = bus.dout;
      oe = bus.douten;
      bus.sck = 1'b1;
      repeat (H) @(negedge clk);
      bus.sck = 1'b0;
   endtask

   task automatic begin_tx();
      bus.ce_n = 1'b0;
      repeat (H) @(negedge clk);
      chk("busy_start", busy, 1'b1);
   endtask

   task automatic end_tx();
      repeat (H) @(negedge clk);
      bus.ce_n = 1'b1;
      repeat (H) @(negedge clk);
      chk("busy_end", busy, 1'b0);
      chk("oe_end", bus.douten, 4'h0);
   endtask

   task automatic hdr(input logic [7:0] cmd, input int a);
      logic [23:0] a24;
      logic [3:0]  q, oe;
      a24 = 24'($urandom);
      a24[ADDR_W-1:0] = ADDR_W'(a);
      nib(cmd[7:4], q, oe);
      chk("oe_cmd", oe, 4'h0);
      nib(cmd[3:0], q, oe);
      for (int i = 5; i >= 0; i--) begin
         nib(a24[i*4 +: 4], q, oe);
         chk("oe_addr", oe, 4'h0);
      end
   endtask

   task automatic write_tx(input int a, input logic [7:0] d[$],
                           input bit half, input logic [3:0] hn);
      logic [3:0] q, oe;
      int idx;
      begin_tx();
      hdr(8'h38, a);
      foreach (d[i]) begin
         nib(d[i][7:4], q, oe);
         nib(d[i][3:0], q, oe);
         idx = (a + i) % DEPTH;
         ref_mem[idx] = d[i];
         valid[idx] = 1'b1;
      end
      if (half) nib(hn, q, oe);
      end_tx();
   endtask

   task automatic read_tx(input int a, input int n, input bit abort);
      logic [3:0] q, oe, e;
      int idx;
      begin_tx();
      hdr(8'hEB, a);
      for (int i = 0; i < DUMMY; i++) begin
         nib(4'h0, q, oe);
         chk("oe_dummy", oe, 4'h0);
      end
      for (int j = 0; j < n; j++) begin
         nib(4'(j), q, oe);
         idx = (a + j / 2) % DEPTH;
         e = (j % 2 == 1) ? ref_mem[idx][3:0] : ref_mem[idx][7:4];
         if (valid[idx]) chk("rd_data", q, e);
         chk("rd_oe", oe, 4'hF);
      end
      if (abort) begin
         @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         chk("rst_oe", bus.douten, 4'h0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_dout", bus.dout, 4'h0);
         bus.ce_n = 1'b1;
         bus.sck  = 1'b0;
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         repeat (H) @(negedge clk);
      end else begin
         end_tx();
      end
   endtask

   initial begin
      logic [7:0] d[$];
      logic [3:0] q, oe;
      int a, len, last;
      bus.sck  = 1'b0;
      bus.ce_n = 1'b1;
      bus.din  = 4'h0;
      repeat (4) @(negedge clk);
      chk("rst_oe0", bus.douten, 4'h0);
      chk("rst_dout0", bus.dout, 4'h0);
      chk("rst_busy0", busy, 1'b0);
      chk("rst_err0", err, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      d = '{8'hAB, 8'hCD, 8'h12, 8'h34};
      write_tx(0, d, 1'b0, 4'h0);
      read_tx(0, 8, 1'b0);

      last = DEPTH - 1;
      d = '{8'h55, 8'h66};
      write_tx(last, d, 1'b0, 4'h0);
      read_tx(last, 4, 1'b0);

      begin_tx();
      nib(4'h9, q, oe);
      nib(4'hF, q, oe);
      err_exp++;
      for (int i = 0; i < 12; i++) begin
         nib(4'(i + 3), q, oe);
         chk("oe_ignore", oe, 4'h0);
      end
      end_tx();
      chk("err_bad", err_cnt, err_exp);
      read_tx(0, 8, 1'b0);

      d = '{8'h11, 8'h22};
      write_tx(40, d, 1'b0, 4'h0);
      d = '{8'h78};
      write_tx(40, d, 1'b1, 4'h9);
      read_tx(40, 4, 1'b0);

      read_tx(0, 3, 1'b1);
      read_tx(1, 2, 1'b0);

      for (int it = 0; it < 16; it++) begin
         a = (it % 4 == 0) ? DEPTH - 1 - $urandom_range(0, 2)
                           : $urandom_range(0, DEPTH - 1);
         len = $urandom_range(1, 4);
         d = {};
         for (int k = 0; k < len; k++) d.push_back(8'($urandom));
         write_tx(a, d, $urandom_range(0, 1) == 1, 4'($urandom));
         read_tx((a + DEPTH - 1) % DEPTH, 2 * len + 2, 1'b0);
      end

      repeat (4) @(negedge clk);
      chk("err_total", err_cnt, err_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
